// File: rtl/gravador_jogadas.sv
// gravador_jogadas: records Genius button presses into a 16x4 memory with a 1-cycle read port.
// Optional macro GRAVADOR_ECO_EN echoes botoes on leds while recording.
`default_nettype none

module gravador_jogadas #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 20000,
  parameter int T_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [3:0]        botoes,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        rd_data,
  output logic [ADDR_W-1:0] tamanho,
  output logic              gravando,
  output logic              valida,
  output logic              pronto,
  output logic              erro,
  output logic              timeout,
  output logic [3:0]        leds,
  output logic [2:0]        db_estado
);

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    ESPERA   = 3'd1,
    REGISTRA = 3'd2,
    PROXIMO  = 3'd3,
    FIM      = 3'd4,
    ERRO     = 3'd5
  } estado_t;

  estado_t           estado_q;
  logic [ADDR_W-1:0] endereco_q;
  logic [ADDR_W-1:0] tamanho_q;
  logic [T_W-1:0]    timer_q;
  logic [3:0]        jog_q;
  logic              sinal_ant_q;
  logic              valida_q;
  logic              pronto_q;
  logic              erro_q;
  logic              timeout_q;
  logic              gravando_q;
  logic [3:0]        rd_data_q;
  logic [3:0]        mem_q [DEPTH];

  logic sinal;
  logic jogada;
  logic botao_unico;
  logic expirou;
  logic cheio;

  assign sinal       = |botoes;
  assign jogada      = sinal & ~sinal_ant_q;
  assign botao_unico = (botoes != 4'b0) && ((botoes & (botoes - 4'd1)) == 4'b0);
  assign expirou     = (timer_q == T_W'(TIMEOUT - 1));
  assign cheio       = (endereco_q == ADDR_W'(DEPTH - 1));

  // Edge history is tracked in every state so a button held across a state
  // change can never produce a late edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sinal_ant_q <= 1'b0;
    end else begin
      sinal_ant_q <= sinal;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= INICIAL;
      endereco_q <= '0;
      tamanho_q  <= '0;
      timer_q    <= '0;
      jog_q      <= 4'b0;
      valida_q   <= 1'b0;
      pronto_q   <= 1'b0;
      erro_q     <= 1'b0;
      timeout_q  <= 1'b0;
      gravando_q <= 1'b0;
    end else begin
      pronto_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (estado_q)
        INICIAL: begin
          if (iniciar) begin
            estado_q   <= ESPERA;
            endereco_q <= '0;
            timer_q    <= '0;
            valida_q   <= 1'b0;
            tamanho_q  <= '0;
            gravando_q <= 1'b1;
          end
        end
        ESPERA: begin
          timer_q <= timer_q + 1'b1;
          if (jogada) begin
            if (botao_unico) begin
              jog_q    <= botoes;
              estado_q <= REGISTRA;
            end else begin
              estado_q   <= ERRO;
              erro_q     <= 1'b1;
              valida_q   <= 1'b0;
              gravando_q <= 1'b0;
            end
          end else if (expirou) begin
            timeout_q  <= 1'b1;
            gravando_q <= 1'b0;
            if (endereco_q != '0) begin
              estado_q <= FIM;
              pronto_q <= 1'b1;
            end else begin
              estado_q <= ERRO;
              erro_q   <= 1'b1;
              valida_q <= 1'b0;
            end
          end
        end
        REGISTRA: begin
          tamanho_q <= endereco_q;
          estado_q  <= PROXIMO;
        end
        PROXIMO: begin
          timer_q <= '0;
          if (cheio) begin
            estado_q   <= FIM;
            pronto_q   <= 1'b1;
            gravando_q <= 1'b0;
          end else begin
            endereco_q <= endereco_q + 1'b1;
            estado_q   <= ESPERA;
          end
        end
        FIM: begin
          valida_q <= 1'b1;
          estado_q <= INICIAL;
        end
        ERRO: begin
          if (iniciar) begin
            estado_q   <= ESPERA;
            endereco_q <= '0;
            timer_q    <= '0;
            tamanho_q  <= '0;
            erro_q     <= 1'b0;
            gravando_q <= 1'b1;
          end
        end
        default: begin
          estado_q <= INICIAL;
        end
      endcase
    end
  end

  // Memory is intentionally not reset so recorded words survive a reset.
  always_ff @(posedge clock) begin
    if (estado_q == REGISTRA) begin
      mem_q[endereco_q] <= jog_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= 4'b0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data   = rd_data_q;
  assign tamanho   = tamanho_q;
  assign gravando  = gravando_q;
  assign valida    = valida_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;
  assign timeout   = timeout_q;
  assign db_estado = estado_q;

`ifdef GRAVADOR_ECO_EN
  assign leds = gravando_q ? botoes : 4'b0;
`else
  assign leds = 4'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gravador_jogadas.sv
// Scoreboard bench for gravador_jogadas: read-back words are queued on address drive and checked one cycle later.
`default_nettype none

module tb_gravador_jogadas;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       iniciar;
  logic [3:0] botoes;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;
  logic [3:0] tamanho;
  logic       gravando;
  logic       valida;
  logic       pronto;
  logic       erro;
  logic       timeout;
  logic [3:0] leds;
  logic [2:0] db_estado;

  int total = 0;
  int bad   = 0;

  logic [3:0] model_mem [16];
  logic [3:0] exp_q [$];
  logic [3:0] eco_exp;

  gravador_jogadas #(.DEPTH(16), .ADDR_W(4), .TIMEOUT(TO), .T_W(16)) dut (
    .clock(clk), .reset(rst), .iniciar(iniciar), .botoes(botoes),
    .rd_addr(rd_addr), .rd_data(rd_data), .tamanho(tamanho),
    .gravando(gravando), .valida(valida), .pronto(pronto), .erro(erro),
    .timeout(timeout), .leds(leds), .db_estado(db_estado)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the number of cycles until timeout (which=0) or pronto (which=1), or -1.
  task automatic wait_for(input int which, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if ((which == 0 && timeout) || (which == 1 && pronto)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    cyc(1);
    iniciar = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; iniciar = 1'b0; botoes = 4'b0; rd_addr = 4'd0;
    cyc(3);
    total++; if (db_estado !== 3'd0 || valida !== 1'b0 || pronto !== 1'b0 || erro !== 1'b0) begin
      bad++; $display("FAIL reset_flags: estado=%0d valida=%b pronto=%b erro=%b, want 0/0/0/0", db_estado, valida, pronto, erro); end
    total++; if (timeout !== 1'b0 || gravando !== 1'b0 || tamanho !== 4'd0 || rd_data !== 4'd0 || leds !== 4'd0) begin
      bad++; $display("FAIL reset_data: timeout=%b gravando=%b tamanho=%0d rd_data=%b leds=%b, want zeros", timeout, gravando, tamanho, rd_data, leds); end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_basic();
    int n;
    logic [3:0] vals [3];
    vals[0] = 4'b0001; vals[1] = 4'b0100; vals[2] = 4'b1000;
    pulse_iniciar();
    total++; if (db_estado !== 3'd1 || gravando !== 1'b1) begin
      bad++; $display("FAIL start: estado=%0d gravando=%b, want 1/1", db_estado, gravando); end
    for (int i = 0; i < 3; i++) begin
      botoes = vals[i];
      cyc(4);
`ifdef GRAVADOR_ECO_EN
      eco_exp = vals[i];
`else
      eco_exp = 4'b0;
`endif
      total++; if (leds !== eco_exp) begin
        bad++; $display("FAIL leds_echo: leds=%b, want %b", leds, eco_exp); end
      cyc(1);
      botoes = 4'b0;
      model_mem[i] = vals[i];
      cyc(10);
    end
    wait_for(0, TO + 40, n);
    total++; if (n < 0 || pronto !== 1'b1 || db_estado !== 3'd4) begin
      bad++; $display("FAIL basic_timeout: n=%0d pronto=%b estado=%0d, want n>0 pronto=1 estado=4", n, pronto, db_estado); end
    cyc(1);
    total++; if (valida !== 1'b1 || tamanho !== 4'd2 || pronto !== 1'b0 || db_estado !== 3'd0) begin
      bad++; $display("FAIL basic_end: valida=%b tamanho=%0d pronto=%b estado=%0d, want 1/2/0/0", valida, tamanho, pronto, db_estado); end
    for (int i = 0; i <= 3; i++) begin
      if (exp_q.size() > 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        total++; if (rd_data !== e) begin
          bad++; $display("FAIL basic_read: rd_data=%b, want %b", rd_data, e); end
      end
      if (i < 3) begin
        rd_addr = 4'(i);
        exp_q.push_back(model_mem[i]);
      end
      cyc(1);
    end
  endtask

  task automatic test_error_and_exact_timeout();
    pulse_iniciar();
    botoes = 4'b0011;
    cyc(1);
    total++; if (erro !== 1'b1 || db_estado !== 3'd5 || valida !== 1'b0) begin
      bad++; $display("FAIL multi_press: erro=%b estado=%0d valida=%b, want 1/5/0", erro, db_estado, valida); end
    botoes = 4'b0;
    cyc(2);
    pulse_iniciar();
    botoes = 4'b0010;
    cyc(2);
    botoes = 4'b0;
    model_mem[0] = 4'b0010;
    cyc(TO);
    total++; if (timeout !== 1'b0) begin
      bad++; $display("FAIL timeout_early: timeout=%b, want 0", timeout); end
    cyc(1);
    total++; if (timeout !== 1'b1 || pronto !== 1'b1) begin
      bad++; $display("FAIL timeout_exact: timeout=%b pronto=%b, want 1/1", timeout, pronto); end
    cyc(1);
    total++; if (valida !== 1'b1 || tamanho !== 4'd0 || timeout !== 1'b0) begin
      bad++; $display("FAIL single_play: valida=%b tamanho=%0d timeout=%b, want 1/0/0", valida, tamanho, timeout); end
    rd_addr = 4'd0;
    exp_q.push_back(model_mem[0]);
    cyc(1);
    begin
      logic [3:0] e;
      e = exp_q.pop_front();
      total++; if (rd_data !== e) begin
        bad++; $display("FAIL single_read: rd_data=%b, want %b", rd_data, e); end
    end
  endtask

  task automatic test_tie();
    int n;
    pulse_iniciar();
    cyc(TO - 1);
    botoes = 4'b0100;
    cyc(1);
    total++; if (db_estado !== 3'd2 || timeout !== 1'b0) begin
      bad++; $display("FAIL tie_play_wins: estado=%0d timeout=%b, want 2/0", db_estado, timeout); end
    botoes = 4'b0;
    model_mem[0] = 4'b0100;
    wait_for(1, TO + 20, n);
    total++; if (n < 0 || timeout !== 1'b1) begin
      bad++; $display("FAIL tie_end: n=%0d timeout=%b, want n>0 timeout=1", n, timeout); end
    cyc(1);
  endtask

  task automatic test_full();
    pulse_iniciar();
    for (int i = 0; i < 15; i++) begin
      botoes = 4'(1 << (i % 4));
      model_mem[i] = botoes;
      cyc(2);
      botoes = 4'b0;
      cyc(2);
    end
    botoes = 4'b1000;
    model_mem[15] = 4'b1000;
    cyc(2);
    botoes = 4'b0;
    cyc(1);
    total++; if (pronto !== 1'b1 || db_estado !== 3'd4 || tamanho !== 4'd15 || timeout !== 1'b0) begin
      bad++; $display("FAIL full: pronto=%b estado=%0d tamanho=%0d timeout=%b, want 1/4/15/0", pronto, db_estado, tamanho, timeout); end
    cyc(1);
    total++; if (valida !== 1'b1 || pronto !== 1'b0) begin
      bad++; $display("FAIL full_end: valida=%b pronto=%b, want 1/0", valida, pronto); end
    botoes = 4'b0100;
    cyc(2);
    total++; if (db_estado !== 3'd0 || leds !== 4'b0) begin
      bad++; $display("FAIL idle_press: estado=%0d leds=%b, want 0/0000", db_estado, leds); end
    botoes = 4'b0;
    for (int i = 0; i <= 4; i++) begin
      if (exp_q.size() > 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        total++; if (rd_data !== e) begin
          bad++; $display("FAIL full_read: rd_data=%b, want %b", rd_data, e); end
      end
      if (i < 4) begin
        rd_addr = 4'(i * 5);
        exp_q.push_back(model_mem[i * 5]);
      end
      cyc(1);
    end
  endtask

  task automatic test_held_button();
    int n;
    botoes = 4'b0001;
    cyc(2);
    pulse_iniciar();
    cyc(8);
    total++; if (db_estado !== 3'd1) begin
      bad++; $display("FAIL held_no_edge: estado=%0d, want 1", db_estado); end
    botoes = 4'b0;
    cyc(3);
    botoes = 4'b1000;
    model_mem[0] = 4'b1000;
    cyc(3);
    botoes = 4'b0;
    wait_for(1, TO + 20, n);
    total++; if (n < 0) begin
      bad++; $display("FAIL held_end: n=%0d, want pronto seen", n); end
    cyc(1);
    total++; if (valida !== 1'b1 || tamanho !== 4'd0) begin
      bad++; $display("FAIL held_result: valida=%b tamanho=%0d, want 1/0", valida, tamanho); end
    rd_addr = 4'd0;
    exp_q.push_back(model_mem[0]);
    cyc(1);
    begin
      logic [3:0] e;
      e = exp_q.pop_front();
      total++; if (rd_data !== e) begin
        bad++; $display("FAIL held_read: rd_data=%b, want %b", rd_data, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] vals [3];
    vals[0] = 4'b0010; vals[1] = 4'b0100; vals[2] = 4'b0001;
    pulse_iniciar();
    for (int i = 0; i < 2; i++) begin
      botoes = vals[i];
      model_mem[i] = vals[i];
      cyc(3);
      botoes = 4'b0;
      cyc(3);
    end
    botoes = vals[2];
    model_mem[2] = vals[2];
    cyc(2);
    total++; if (db_estado !== 3'd3) begin
      bad++; $display("FAIL pre_reset_state: estado=%0d, want 3", db_estado); end
    rst = 1'b1;
    cyc(1);
    total++; if (db_estado !== 3'd0 || valida !== 1'b0 || tamanho !== 4'd0) begin
      bad++; $display("FAIL mid_reset: estado=%0d valida=%b tamanho=%0d, want 0/0/0", db_estado, valida, tamanho); end
    rst = 1'b0;
    botoes = 4'b0;
    cyc(1);
    for (int i = 0; i <= 3; i++) begin
      if (exp_q.size() > 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        total++; if (rd_data !== e) begin
          bad++; $display("FAIL retained_read: rd_data=%b, want %b", rd_data, e); end
      end
      if (i < 3) begin
        rd_addr = 4'(i);
        exp_q.push_back(model_mem[i]);
      end
      cyc(1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error_and_exact_timeout();
    test_tie();
    test_full();
    test_held_button();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
